// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared types and helpers for the clock monitor blocks
package clk_mon_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    HIGH,
    LOW
  } meas_state_e;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/clk_ratio_phase_cnt.sv
// rtl/clk_ratio_phase_cnt.sv - saturating phase counter with clear, load-to-one and max flag
module clk_ratio_phase_cnt
  import clk_mon_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         i_ref_clk,
  input  logic         i_rst,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge i_ref_clk) begin
    if (i_rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(1);
    end else if (inc) begin
      cnt <= W'(sat_add(32'(cnt), 32'd1, 32'(MAX)));
    end
  end

  assign at_max = (cnt == MAX);

endmodule

// File: rtl/clk_ratio_meter.sv
// rtl/clk_ratio_meter.sv - period/high/low meter with lock detect; CLK_RATIO_DUTY_EN adds duty check
module clk_ratio_meter
  import clk_mon_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_CNT = 2
) (
  input  logic             i_ref_clk,
  input  logic             i_rst,
  input  logic             i_meas_en,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_ratio,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_low_cnt,
  output logic             o_odd,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_duty_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       LOCK_MAX = 3'(LOCK_CNT);

  meas_state_e      state, nxt_state;
  logic             sig_d, rise, fall;
  logic [CNT_W-1:0] hcnt, lcnt, unused_tcnt, sum, prev_ratio;
  logic             h_max, l_max, t_max;
  logic             h_clr, h_ld, h_inc, l_clr, l_ld, l_inc, t_clr, t_inc;
  logic             period_done, ovf_err, have_prev;
  logic [2:0]       lock_cnt;

  assign rise = i_sig & ~sig_d;
  assign fall = ~i_sig & sig_d;
  assign sum  = CNT_W'(sat_add(32'(hcnt), 32'(lcnt), 32'(CNT_MAX)));

  clk_ratio_phase_cnt #(.W(CNT_W)) u_hcnt (
    .i_ref_clk(i_ref_clk), .i_rst(i_rst), .clr(h_clr), .load(h_ld), .inc(h_inc),
    .cnt(hcnt), .at_max(h_max));
  clk_ratio_phase_cnt #(.W(CNT_W)) u_lcnt (
    .i_ref_clk(i_ref_clk), .i_rst(i_rst), .clr(l_clr), .load(l_ld), .inc(l_inc),
    .cnt(lcnt), .at_max(l_max));
  clk_ratio_phase_cnt #(.W(CNT_W)) u_tcnt (
    .i_ref_clk(i_ref_clk), .i_rst(i_rst), .clr(t_clr), .load(1'b0), .inc(t_inc),
    .cnt(unused_tcnt), .at_max(t_max));

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state <= IDLE;
      sig_d <= 1'b0;
    end else begin
      state <= nxt_state;
      sig_d <= i_sig;
    end
  end

  always_comb begin
    nxt_state   = state;
    h_clr = 1'b0; h_ld = 1'b0; h_inc = 1'b0;
    l_clr = 1'b0; l_ld = 1'b0; l_inc = 1'b0;
    t_clr = 1'b0; t_inc = 1'b0;
    period_done = 1'b0;
    ovf_err     = 1'b0;
    if (!i_meas_en) begin
      nxt_state = IDLE;
      h_clr = 1'b1; l_clr = 1'b1; t_clr = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          nxt_state = WAIT_RISE;
          h_clr = 1'b1; l_clr = 1'b1; t_clr = 1'b1;
        end
        WAIT_RISE: begin
          if (rise) begin
            nxt_state = HIGH;
            h_ld = 1'b1; l_clr = 1'b1; t_clr = 1'b1;
          end else if (t_max) begin
            ovf_err = 1'b1;
            t_clr   = 1'b1;
          end else begin
            t_inc = 1'b1;
          end
        end
        HIGH: begin
          if (h_max) begin
            ovf_err   = 1'b1;
            nxt_state = WAIT_RISE;
            h_clr = 1'b1; l_clr = 1'b1; t_clr = 1'b1;
          end else if (fall) begin
            nxt_state = LOW;
            l_ld = 1'b1;
          end else begin
            h_inc = 1'b1;
          end
        end
        LOW: begin
          if (l_max) begin
            ovf_err   = 1'b1;
            nxt_state = WAIT_RISE;
            h_clr = 1'b1; l_clr = 1'b1; t_clr = 1'b1;
          end else if (rise) begin
            // the rising edge that closes this period also opens the next one
            period_done = 1'b1;
            nxt_state   = HIGH;
            h_ld = 1'b1; l_clr = 1'b1;
          end else begin
            l_inc = 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      o_ratio    <= '0;
      o_high_cnt <= '0;
      o_low_cnt  <= '0;
      o_valid    <= 1'b0;
      o_locked   <= 1'b0;
      o_err      <= 1'b0;
      lock_cnt   <= '0;
      prev_ratio <= '0;
      have_prev  <= 1'b0;
    end else begin
      o_valid <= period_done;
      if (!i_meas_en) begin
        lock_cnt  <= '0;
        o_locked  <= 1'b0;
        o_err     <= 1'b0;
        have_prev <= 1'b0;
      end else if (ovf_err) begin
        o_err     <= 1'b1;
        o_locked  <= 1'b0;
        lock_cnt  <= '0;
        have_prev <= 1'b0;
      end else if (period_done) begin
        o_ratio    <= sum;
        o_high_cnt <= hcnt;
        o_low_cnt  <= lcnt;
        prev_ratio <= sum;
        have_prev  <= 1'b1;
        if (have_prev) begin
          if (sum == prev_ratio) begin
            if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 3'd1;
            if (lock_cnt >= LOCK_MAX - 3'd1) o_locked <= 1'b1;
          end else begin
            lock_cnt <= '0;
            o_locked <= 1'b0;
          end
        end
      end
    end
  end

  assign o_odd = o_ratio[0];

`ifdef CLK_RATIO_DUTY_EN
  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
  logic duty_bad;
  assign duty_bad = ({1'b0, hcnt} > {1'b0, lcnt} + ONE) ||
                    ({1'b0, lcnt} > {1'b0, hcnt} + ONE);

  always_ff @(posedge i_ref_clk) begin
    if (i_rst || !i_meas_en) begin
      o_duty_err <= 1'b0;
    end else if (period_done) begin
      o_duty_err <= duty_bad;
    end
  end
`else
  assign o_duty_err = 1'b0;
`endif

endmodule

// File: doc/clk_ratio_meter.md
Name: clk_ratio_meter

Overview:
- Measures the period, high time and low time of a slow square wave, counted in i_ref_clk cycles.
- The square wave is typically a divided clock looped back as a data signal.
- It is the receive-side checker for the clock divider: it recovers the division ratio the divider actually produced, flags odd ratios, and declares lock once consecutive periods agree.
- Sits in the clock-control/monitor area; its outputs feed status registers and self-test logic.

Parameters:
- CNT_W, 8, width of all period/phase counters and ratio outputs.
- LOCK_CNT, 2, number of consecutive identical periods (after the first) required for lock; legal range 1..7.

Ports:
- i_ref_clk  in  1  reference clock; all logic on posedge.
- i_rst  in  1  synchronous reset, active-high.
- i_meas_en  in  1  measurement enable; low forces IDLE.
- i_sig  in  1  signal under measurement; already synchronous to i_ref_clk, sampled each posedge.
- o_ratio  out  CNT_W  last measured period (high+low) in ref cycles.
- o_high_cnt  out  CNT_W  high phase of last period.
- o_low_cnt  out  CNT_W  low phase of last period.
- o_odd  out  1  o_ratio[0].
- o_valid  out  1  one-cycle pulse when o_ratio/o_high_cnt/o_low_cnt update.
- o_locked  out  1  LOCK_CNT consecutive matching periods seen.
- o_err  out  1  sticky timeout/overflow flag; cleared by reset or i_meas_en low.
- o_duty_err  out  1  duty check result (see Optional Feature).

Behaviour:
- Reset: all outputs 0; state IDLE; sig_d (previous sample) = 0; counters 0.
- Edge detect: rise = i_sig & ~sig_d; fall = ~i_sig & sig_d; sig_d <= i_sig every cycle, including in IDLE.
- States:
  - IDLE: i_meas_en=1 -> WAIT_RISE.
  - WAIT_RISE: rise -> HIGH with hcnt=1, lcnt=0.
  - HIGH: i_sig=1 -> hcnt++; fall -> LOW with lcnt=1.
  - LOW: i_sig=0 -> lcnt++; rise -> period complete:
    - o_ratio <= hcnt+lcnt; o_high_cnt <= hcnt; o_low_cnt <= lcnt; o_valid pulses next cycle;
    - then hcnt=1, lcnt=0, stay in the HIGH cycle of measurement.
- Latency: outputs register one cycle after the rise is sampled; o_valid is high for exactly that cycle.
- Arithmetic: hcnt/lcnt saturate at 2^CNT_W-1; the sum saturates at 2^CNT_W-1.
- Overflow/timeout: hcnt or lcnt reaching 2^CNT_W-1, or WAIT_RISE lasting 2^CNT_W cycles:
  - o_err <= 1, o_locked <= 0, lock counter <= 0;
  - state -> WAIT_RISE, counters 0; no o_valid for that period.
- Lock:
  - On each completed period, compare to the previous completed period.
  - Equal: lock_cnt++ (saturating at LOCK_CNT); reaching LOCK_CNT sets o_locked.
  - Differ: lock_cnt=0, o_locked=0.
  - The first period after IDLE/WAIT_RISE has no predecessor: it loads the compare register only.
  - Odd ratios alternate high/low split (e.g. 2/3, 3/2), but the period is equal, so lock is unaffected.
- i_meas_en low in any state: next cycle IDLE; counters, lock_cnt, o_locked, o_err cleared; o_ratio/o_high_cnt/o_low_cnt hold.
- i_rst has priority over i_meas_en and over any simultaneous edge.
- Constant i_sig (divider bypass, ratio 0/1 sampled at posedge) -> timeout path, o_err=1.

Optional Feature:
- Macro CLK_RATIO_DUTY_EN.
- Defined: with each o_valid, o_duty_err <= (|o_high_cnt - o_low_cnt| > 1), computed from the new values; held until the next update; cleared like o_err.
- Undefined: no duty logic; o_duty_err tied 0.

Decomposition:
- Shared package clk_mon_pkg:
  - state enum (IDLE, WAIT_RISE, HIGH, LOW);
  - CNT_W default constant;
  - saturating-add function.
- One natural sub-module: clk_ratio_phase_cnt, a saturating phase counter with clear/load and a max flag, instantiated for hcnt, lcnt and the timeout count.

Test Plan:
- i_sig = clkdiv output, ratio 4, en=1 -> o_ratio=4, high=2, low=2, o_odd=0; o_locked=1 after the 3rd period (LOCK_CNT=2); o_valid once per 4 cycles.
- Ratio 5 -> o_ratio=5, o_odd=1; high/low alternate 2/3 and 3/2; o_locked=1; o_duty_err=0 with macro.
- Hold i_sig=1 for 300 cycles after a rise (CNT_W=8) -> o_err=1 at hcnt=255, o_locked=0; recovers with a new valid ratio after the next clean periods.
- Ratio changes 6->8 mid-run -> first 8-period update drops o_locked on that o_valid; relocks after 2 more matching periods.
- i_meas_en dropped mid-HIGH, re-raised -> IDLE next cycle, o_err/o_locked=0, first new o_valid only after a full rise-to-rise period.
- Macro on, i_sig high 1 cycle / low 5 cycles -> o_ratio=6, o_duty_err=1; i_rst pulse mid-LOW -> all outputs 0 next cycle.
